// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the external memory bus between instruction fetch and data access
// and owns the pipeline stall vector.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [3:0]        mem_sel,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,
    input  logic              stallreq_id,
    input  logic              stallreq_ex,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [3:0]        bus_sel,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              bus_err,
    output logic [5:0]        stall
);
    typedef enum logic [1:0] {IDLE, IF_ACC, MEM_ACC} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]        bus_sel_q, bus_sel_d;
    logic              bus_err_q, bus_err_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic              if_done_q, if_done_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              mem_done_q, mem_done_d;

    always_comb begin
        stall = rst                       ? 6'b000000 :
                (mem_req && !mem_done_q)  ? 6'b011111 :
                stallreq_ex               ? 6'b001111 :
                stallreq_id               ? 6'b000111 :
                (if_req && !if_done_q)    ? 6'b000011 : 6'b000000;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_sel_d   = bus_sel_q;
        bus_err_d   = bus_err_q;
        // results are consumed on the first edge the owning stage advances
        if_done_d   = stall[1] ? if_done_q  : 1'b0;
        if_rdata_d  = stall[1] ? if_rdata_q : '0;
        mem_done_d  = stall[4] ? mem_done_q  : 1'b0;
        mem_rdata_d = stall[4] ? mem_rdata_q : '0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (mem_req && !mem_done_q) begin
                    state_d     = MEM_ACC;
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_we;
                    bus_addr_d  = mem_addr;
                    bus_wdata_d = mem_wdata;
                    bus_sel_d   = mem_sel;
                end else if (if_req && !if_done_q) begin
                    state_d    = IF_ACC;
                    bus_req_d  = 1'b1;
                    bus_we_d   = 1'b0;
                    bus_addr_d = if_addr;
                    bus_sel_d  = 4'b1111;
                end
            end
            IF_ACC, MEM_ACC: begin
                cnt_d = cnt_q + 8'd1;
                if (bus_ack || cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    bus_req_d = 1'b0;
                    bus_err_d = bus_err_q | !bus_ack;
                    if (state_q == IF_ACC) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = bus_ack ? bus_rdata : '0;
                    end else begin
                        mem_done_d  = 1'b1;
                        mem_rdata_d = (bus_ack && !bus_we_q) ? bus_rdata : '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_sel_q   <= '0;
            bus_err_q   <= 1'b0;
            if_rdata_q  <= '0;
            if_done_q   <= 1'b0;
            mem_rdata_q <= '0;
            mem_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_sel_q   <= bus_sel_d;
            bus_err_q   <= bus_err_d;
            if_rdata_q  <= if_rdata_d;
            if_done_q   <= if_done_d;
            mem_rdata_q <= mem_rdata_d;
            mem_done_q  <= mem_done_d;
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_sel   = bus_sel_q;
    assign bus_err   = bus_err_q;
    assign if_rdata  = if_rdata_q;
    assign if_done   = if_done_q;
    assign mem_rdata = mem_rdata_q;
    assign mem_done  = mem_done_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of bus sequencing, stall priority, result retention,
// timeout and reset abort for mem_arbiter (TIMEOUT=4).
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0, mem_req = 1'b0, mem_we = 1'b0;
    logic        stallreq_id = 1'b0, stallreq_ex = 1'b0, bus_ack = 1'b0;
    logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0, bus_rdata = '0;
    logic [3:0]  mem_sel = '0;
    logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
    logic        if_done, mem_done, bus_req, bus_we, bus_err;
    logic [3:0]  bus_sel;
    logic [5:0]  stall;
    int          passed = 0, total = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_sel(mem_sel), .mem_rdata(mem_rdata), .mem_done(mem_done),
        .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_sel(bus_sel), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err),
        .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    endtask

    initial begin
        if_req = 1'b1;
        tick();
        tick();
        #1;
        chk("rst_stall", stall, 6'b000000);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_sel", bus_sel, 0);
        chk("rst_if_done", if_done, 0);
        chk("rst_mem_done", mem_done, 0);
        chk("rst_bus_err", bus_err, 0);
        // fetch only, ack in second ACC cycle
        if_req = 1'b0;
        rst = 1'b0;
        tick();
        if_req = 1'b1;
        if_addr = 32'h100;
        #1;
        chk("f_stall_idle", stall, 6'b000011);
        tick();
        chk("f_bus_req", bus_req, 1);
        chk("f_bus_addr", bus_addr, 32'h100);
        chk("f_bus_sel", bus_sel, 4'hF);
        chk("f_bus_we", bus_we, 0);
        tick();
        chk("f_wait_done", if_done, 0);
        bus_ack = 1'b1;
        bus_rdata = 32'h3C010001;
        #1;
        chk("f_stall_acc", stall, 6'b000011);
        tick();
        bus_ack = 1'b0;
        #1;
        chk("f_if_done", if_done, 1);
        chk("f_if_rdata", if_rdata, 32'h3C010001);
        chk("f_bus_req_off", bus_req, 0);
        chk("f_stall_done", stall, 6'b000000);
        tick();
        if_req = 1'b0;
        #1;
        chk("f_if_done_clr", if_done, 0);
        chk("f_if_rdata_clr", if_rdata, 0);
        chk("f_no_reissue", bus_req, 0);
        // simultaneous IF and MEM load: MEM first
        tick();
        if_req = 1'b1;
        if_addr = 32'h104;
        mem_req = 1'b1;
        mem_we = 1'b0;
        mem_addr = 32'h2000;
        mem_sel = 4'hF;
        #1;
        chk("s_stall_mem", stall, 6'b011111);
        tick();
        chk("s_bus_addr_mem", bus_addr, 32'h2000);
        chk("s_bus_we", bus_we, 0);
        chk("s_bus_req", bus_req, 1);
        bus_ack = 1'b1;
        bus_rdata = 32'h11223344;
        tick();
        bus_ack = 1'b0;
        #1;
        chk("s_mem_done", mem_done, 1);
        chk("s_mem_rdata", mem_rdata, 32'h11223344);
        chk("s_if_not_done", if_done, 0);
        chk("s_stall_if", stall, 6'b000011);
        tick();
        mem_req = 1'b0;
        #1;
        chk("s_mem_done_clr", mem_done, 0);
        chk("s_if_issued", bus_req, 1);
        chk("s_bus_addr_if", bus_addr, 32'h104);
        bus_ack = 1'b1;
        bus_rdata = 32'hAABBCCDD;
        tick();
        bus_ack = 1'b0;
        if_req = 1'b0;
        #1;
        chk("s_if_done", if_done, 1);
        chk("s_if_rdata", if_rdata, 32'hAABBCCDD);
        tick();
        chk("s_if_done_clr", if_done, 0);
        // store: bus held stable even when inputs change
        mem_req = 1'b1;
        mem_we = 1'b1;
        mem_addr = 32'h3000;
        mem_wdata = 32'hDEADBEEF;
        mem_sel = 4'b0011;
        tick();
        mem_wdata = 32'h0;
        mem_addr = 32'h0;
        mem_sel = 4'hF;
        #1;
        chk("w_bus_we", bus_we, 1);
        chk("w_bus_wdata", bus_wdata, 32'hDEADBEEF);
        chk("w_bus_sel", bus_sel, 4'b0011);
        tick();
        chk("w_hold_addr", bus_addr, 32'h3000);
        chk("w_hold_wdata", bus_wdata, 32'hDEADBEEF);
        bus_ack = 1'b1;
        bus_rdata = 32'h55555555;
        tick();
        bus_ack = 1'b0;
        mem_req = 1'b0;
        mem_we = 1'b0;
        #1;
        chk("w_mem_done", mem_done, 1);
        chk("w_mem_rdata", mem_rdata, 0);
        tick();
        chk("w_mem_done_clr", mem_done, 0);
        // retention under downstream stall
        if_req = 1'b1;
        if_addr = 32'h200;
        tick();
        bus_ack = 1'b1;
        bus_rdata = 32'h12345678;
        stallreq_ex = 1'b1;
        tick();
        bus_ack = 1'b0;
        #1;
        chk("r_if_done", if_done, 1);
        chk("r_stall", stall, 6'b001111);
        tick();
        chk("r_hold_done1", if_done, 1);
        chk("r_hold_rdata1", if_rdata, 32'h12345678);
        chk("r_no_reissue1", bus_req, 0);
        tick();
        chk("r_hold_done2", if_done, 1);
        chk("r_no_reissue2", bus_req, 0);
        stallreq_ex = 1'b0;
        #1;
        chk("r_stall_clear", stall, 6'b000000);
        tick();
        if_req = 1'b0;
        #1;
        chk("r_if_done_clr", if_done, 0);
        chk("r_no_reissue3", bus_req, 0);
        // timeout on a load with no ack
        mem_req = 1'b1;
        mem_addr = 32'h4000;
        tick();
        chk("t_acc1", bus_req, 1);
        tick();
        tick();
        tick();
        chk("t_acc4_req", bus_req, 1);
        chk("t_acc4_err", bus_err, 0);
        tick();
        mem_req = 1'b0;
        #1;
        chk("t_abort_req", bus_req, 0);
        chk("t_bus_err", bus_err, 1);
        chk("t_mem_done", mem_done, 1);
        chk("t_mem_rdata", mem_rdata, 0);
        tick();
        tick();
        chk("t_err_sticky", bus_err, 1);
        chk("t_mem_done_clr", mem_done, 0);
        // reset during MEM_ACC with ack in the same cycle
        mem_req = 1'b1;
        mem_addr = 32'h5000;
        tick();
        chk("x_acc", bus_req, 1);
        rst = 1'b1;
        bus_ack = 1'b1;
        bus_rdata = 32'h99;
        #1;
        chk("x_stall_rst", stall, 6'b000000);
        tick();
        rst = 1'b0;
        bus_ack = 1'b0;
        mem_req = 1'b0;
        #1;
        chk("x_bus_req", bus_req, 0);
        chk("x_bus_addr", bus_addr, 0);
        chk("x_mem_done", mem_done, 0);
        chk("x_mem_rdata", mem_rdata, 0);
        chk("x_bus_err", bus_err, 0);
        // ack while idle is ignored
        bus_ack = 1'b1;
        bus_rdata = 32'h77;
        tick();
        bus_ack = 1'b0;
        #1;
        chk("i_mem_done", mem_done, 0);
        chk("i_if_done", if_done, 0);
        chk("i_bus_req", bus_req, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
